ae_exposure_controller: RTL and testbench
=========================================

// Module: ae_exposure_controller
// PURPOSE
//  Closed-loop auto-exposure controller. Consumes the per-frame average luma and frame-done pulse
//  from the AE statistics block and steps sensor exposure (lines) and analog gain (Q4.4) toward a
//  target. Hands each new setting to the sensor register writer over a valid/ready handshake, then
//  skips frames while the sensor applies it.
// PARAMETERS
//  EXP_MIN       16    minimum exposure, lines
//  EXP_MAX       1200  maximum exposure, lines (720p30 frame length)
//  EXP_INIT      512   exposure after reset
//  GAIN_MIN      16    minimum gain, Q4.4 (1.0x); also the gain after reset
//  GAIN_MAX      128   maximum gain, Q4.4 (8.0x)
//  DEADBAND      8     |target - avg| <= DEADBAND counts as converged
//  STEP_SHIFT    3     exposure step = exp >> STEP_SHIFT, minimum 1
//  SETTLE_FRAMES 2     frame_done pulses ignored after each accepted write (1..15)
// PORTS
//  clk           in   1   pixel/CSI clock, shared with the statistics block
//  rst_n         in   1   synchronous, active-low reset
//  ae_enable     in   1   1 = loop runs; 0 = hold current setting
//  target_luma   in   8   desired average luma, sampled in CALC
//  avg_luma_in   in   8   average luma from statistics, valid while frame_done_in=1
//  frame_done_in in   1   1-cycle pulse, end of frame
//  exp_out       out  16  exposure to program, lines
//  gain_out      out  8   gain to program, Q4.4
//  cfg_valid     out  1   exp_out/gain_out hold a new setting
//  cfg_ready     in   1   register writer accepts; transfer when cfg_valid && cfg_ready
//  ae_locked     out  1   last evaluated frame was within DEADBAND
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state IDLE, exp_out=EXP_INIT, gain_out=GAIN_MIN, cfg_valid=0,
//    ae_locked=0, settle counter=0. This applies in any state, including mid-handshake
//    (cfg_valid drops without a transfer).
//  States: IDLE, CALC, ISSUE, SETTLE.
//  IDLE: if frame_done_in && ae_enable: latch avg_luma_in, go to CALC. Otherwise stay.
//  CALC (one cycle):
//    err = target_luma - avg (10-bit signed). mag = |err|. step = max(1, exp_out >> STEP_SHIFT).
//    mag <= DEADBAND: set ae_locked=1, no change, go to IDLE.
//    err > 0 (too dark):
//      exp_out < EXP_MAX: exp_out = min(exp_out + step, EXP_MAX).
//      else gain_out < GAIN_MAX: gain_out += 1.
//    err < 0 (too bright):
//      gain_out > GAIN_MIN: gain_out -= 1 (gain is always reduced before exposure).
//      else exp_out = max(exp_out - step, EXP_MIN), computed without unsigned underflow.
//    In both directions: ae_locked=0. If a value changed, go to ISSUE; else (pinned at a limit) go to IDLE.
//    Sums use 17-bit intermediates; clamps apply before register update.
//  ISSUE: cfg_valid=1. exp_out/gain_out are stable while valid is high. Valid drops only on a transfer.
//    On transfer: cfg_valid=0 the next cycle, settle counter loaded with SETTLE_FRAMES, go to SETTLE.
//    frame_done_in pulses here are ignored. ae_enable falling here does not abort the handshake.
//  SETTLE: each frame_done_in decrements the counter; those frames' stats are discarded.
//    When the count hits 0, go to IDLE. The next frame_done is then evaluated.
//    ae_enable=0 in SETTLE: go to IDLE immediately.
//  Latency: frame_done_in at cycle N -> CALC at N+1 -> cfg_valid=1 at N+2.
//    Fastest transfer with cfg_ready=1: cfg_valid is high for 1 cycle.
//  ae_enable=0 in IDLE: outputs hold, ae_locked holds last value.
//  Simultaneous: a frame_done_in in the transfer cycle is ignored. It does not count toward settle.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles -> exp_out=512, gain_out=16, cfg_valid=0, ae_locked=0.
//  2 Dark step: target=110, avg=40, exp=512 -> cfg_valid=1 at N+2, exp_out=576, gain_out=16;
//    hold cfg_ready=0 for 5 cycles -> valid/values stable; ready=1 -> valid drops next cycle.
//  3 Settle: after a transfer, 2 frame_done with avg=0 -> no CALC. 3rd frame avg=40 -> exp 576 -> 648.
//  4 Saturation: exp=1200, gain=16, avg=20 -> exp stays 1200, gain_out=17.
//    Bright frame with gain=17 -> gain 16, exp unchanged.
//  5 Floor/deadband: exp=16, gain=16, avg=250 -> no cfg_valid, ae_locked=0.
//    avg=115 with target 110 -> no cfg_valid, ae_locked=1.
//  6 Reset mid-ISSUE with cfg_ready=0 -> next cycle cfg_valid=0, exp_out=512, state IDLE.

Source files
------------

// File: rtl/ae_exposure_controller.sv
// Closed-loop auto-exposure controller.
// Each evaluated frame moves the exposure (lines) or the analog gain (Q4.4) one
// step toward target_luma. Every new setting is handed to the sensor register
// writer over valid/ready. The controller then skips a fixed number of frames
// while the sensor applies the new setting.
module ae_exposure_controller #(
    parameter int unsigned EXP_MIN       = 16,
    parameter int unsigned EXP_MAX       = 1200,
    parameter int unsigned EXP_INIT      = 512,
    parameter int unsigned GAIN_MIN      = 16,
    parameter int unsigned GAIN_MAX      = 128,
    parameter int unsigned DEADBAND      = 8,
    parameter int unsigned STEP_SHIFT    = 3,
    parameter int unsigned SETTLE_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ae_enable,
    input  logic [7:0]  target_luma,
    input  logic [7:0]  avg_luma_in,
    input  logic        frame_done_in,
    output logic [15:0] exp_out,
    output logic [7:0]  gain_out,
    output logic        cfg_valid,
    input  logic        cfg_ready,
    output logic        ae_locked
);

    typedef enum logic [1:0] {IDLE, CALC, ISSUE, SETTLE} state_t;

    state_t       state, state_nxt;
    logic [15:0]  exp_r, exp_nxt;
    logic [7:0]   gain_r, gain_nxt;
    logic [7:0]   avg_r, avg_nxt;
    logic [3:0]   settle_cnt, settle_nxt;
    logic         locked_r, locked_nxt;

    logic signed [9:0] err;
    logic [9:0]        mag;
    logic [15:0]       step_raw, step;
    logic [16:0]       exp_up;
    logic [16:0]       exp_floor;

    // Luma error and exposure step arithmetic. A 17-bit width keeps the sums from wrapping.
    always_comb begin
        err       = $signed({2'b00, target_luma}) - $signed({2'b00, avg_r});
        mag       = $unsigned(err[9] ? -err : err);
        step_raw  = exp_r >> STEP_SHIFT;
        step      = (step_raw == 16'd0) ? 16'd1 : step_raw;
        exp_up    = {1'b0, exp_r} + {1'b0, step};
        // Subtracting step from exposure only stays above EXP_MIN when exposure >= EXP_MIN + step.
        exp_floor = 17'(EXP_MIN) + {1'b0, step};
    end

    // State, setting and settle-counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            exp_r      <= 16'(EXP_INIT);
            gain_r     <= 8'(GAIN_MIN);
            avg_r      <= 8'd0;
            settle_cnt <= 4'd0;
            locked_r   <= 1'b0;
        end else begin
            state      <= state_nxt;
            exp_r      <= exp_nxt;
            gain_r     <= gain_nxt;
            avg_r      <= avg_nxt;
            settle_cnt <= settle_nxt;
            locked_r   <= locked_nxt;
        end
    end

    // Next-state logic and next values of the registers
    always_comb begin
        state_nxt  = state;
        exp_nxt    = exp_r;
        gain_nxt   = gain_r;
        avg_nxt    = avg_r;
        settle_nxt = settle_cnt;
        locked_nxt = locked_r;
        case (state)
            IDLE: begin
                if (frame_done_in && ae_enable) begin
                    avg_nxt   = avg_luma_in;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                state_nxt = IDLE;
                if (mag <= 10'(DEADBAND)) begin
                    locked_nxt = 1'b1;
                end else if (!err[9]) begin
                    // Too dark: increase exposure first, then gain.
                    locked_nxt = 1'b0;
                    if (exp_r < 16'(EXP_MAX)) begin
                        exp_nxt   = (exp_up > 17'(EXP_MAX)) ? 16'(EXP_MAX) : exp_up[15:0];
                        state_nxt = ISSUE;
                    end else if (gain_r < 8'(GAIN_MAX)) begin
                        gain_nxt  = gain_r + 8'd1;
                        state_nxt = ISSUE;
                    end
                end else begin
                    // Too bright: reduce gain first, which keeps noise low, then reduce exposure.
                    locked_nxt = 1'b0;
                    if (gain_r > 8'(GAIN_MIN)) begin
                        gain_nxt  = gain_r - 8'd1;
                        state_nxt = ISSUE;
                    end else if (exp_r > 16'(EXP_MIN)) begin
                        exp_nxt   = ({1'b0, exp_r} >= exp_floor) ? exp_r - step : 16'(EXP_MIN);
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // Stay in this state until the transfer. Frame pulses and ae_enable are ignored here.
                if (cfg_ready) begin
                    settle_nxt = 4'(SETTLE_FRAMES);
                    state_nxt  = SETTLE;
                end
            end
            SETTLE: begin
                if (!ae_enable) begin
                    state_nxt = IDLE;
                end else if (frame_done_in) begin
                    settle_nxt = settle_cnt - 4'd1;
                    if (settle_cnt <= 4'd1) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign exp_out   = exp_r;
    assign gain_out  = gain_r;
    assign cfg_valid = (state == ISSUE);
    assign ae_locked = locked_r;

endmodule

// File: tb/tb_ae_exposure_controller.sv
// Directed bench for ae_exposure_controller: hand sequences for the reset,
// handshake, settle and floor cases, plus a table of single-frame steps.
module tb_ae_exposure_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ae_enable;
    logic [7:0]  target_luma;
    logic [7:0]  avg_luma_in;
    logic        frame_done_in;
    logic [15:0] exp_out;
    logic [7:0]  gain_out;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        ae_locked;

    int n_total = 0;
    int n_pass  = 0;

    ae_exposure_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ae_enable    (ae_enable),
        .target_luma  (target_luma),
        .avg_luma_in  (avg_luma_in),
        .frame_done_in(frame_done_in),
        .exp_out      (exp_out),
        .gain_out     (gain_out),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .ae_locked    (ae_locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tgt;
        logic [7:0] avg;
        logic       vld;
        int         expv;
        int         gain;
        logic       lock;
    } vec_t;

    vec_t tv[15];

    task automatic check(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    // Called at a negedge. Drives a one-cycle frame pulse and returns at the negedge of the CALC cycle.
    task automatic pulse_frame(input logic [7:0] a);
        frame_done_in = 1'b1;
        avg_luma_in   = a;
        @(negedge clk);
        frame_done_in = 1'b0;
    endtask

    // Drives a frame pulse and returns at the negedge two cycles after the pulse, where cfg_valid is due.
    task automatic eval_frame(input logic [7:0] a, output logic v);
        pulse_frame(a);
        @(negedge clk);
        v = cfg_valid;
    endtask

    // Completes the transfer immediately, then sends the two frames that are discarded while settling.
    task automatic finish_issue();
        cfg_ready = 1'b1;
        @(negedge clk);
        cfg_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pulse_frame(8'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        logic v;
        rst_n = 1'b0; ae_enable = 1'b1; target_luma = 8'd110; avg_luma_in = 8'd0;
        frame_done_in = 1'b0; cfg_ready = 1'b0;

        tv[0]  = '{8'd110, 8'd40,  1'b1, 729,  16, 1'b0};
        tv[1]  = '{8'd110, 8'd40,  1'b1, 820,  16, 1'b0};
        tv[2]  = '{8'd110, 8'd40,  1'b1, 922,  16, 1'b0};
        tv[3]  = '{8'd110, 8'd40,  1'b1, 1037, 16, 1'b0};
        tv[4]  = '{8'd110, 8'd40,  1'b1, 1166, 16, 1'b0};
        tv[5]  = '{8'd110, 8'd40,  1'b1, 1200, 16, 1'b0};
        tv[6]  = '{8'd110, 8'd20,  1'b1, 1200, 17, 1'b0};
        tv[7]  = '{8'd110, 8'd200, 1'b1, 1200, 16, 1'b0};
        tv[8]  = '{8'd110, 8'd200, 1'b1, 1050, 16, 1'b0};
        tv[9]  = '{8'd110, 8'd115, 1'b0, 1050, 16, 1'b1};
        tv[10] = '{8'd110, 8'd102, 1'b0, 1050, 16, 1'b1};
        tv[11] = '{8'd110, 8'd101, 1'b1, 1181, 16, 1'b0};
        tv[12] = '{8'd110, 8'd119, 1'b1, 1034, 16, 1'b0};
        tv[13] = '{8'd200, 8'd190, 1'b1, 1163, 16, 1'b0};
        tv[14] = '{8'd110, 8'd112, 1'b0, 1163, 16, 1'b1};

        // Reset
        repeat (3) @(negedge clk);
        check("rst_exp", int'(exp_out), 512);
        check("rst_gain", int'(gain_out), 16);
        check("rst_valid", int'(cfg_valid), 0);
        check("rst_locked", int'(ae_locked), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Dark step with the register writer stalled for five cycles
        pulse_frame(8'd40);
        check("dark_valid_n1", int'(cfg_valid), 0);
        @(negedge clk);
        check("dark_valid_n2", int'(cfg_valid), 1);
        check("dark_exp", int'(exp_out), 576);
        check("dark_gain", int'(gain_out), 16);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", int'(cfg_valid), 1);
            check("stall_exp", int'(exp_out), 576);
        end
        // Transfer, with a frame pulse in the same cycle that must not count toward settling
        cfg_ready = 1'b1; frame_done_in = 1'b1; avg_luma_in = 8'd0;
        @(negedge clk);
        cfg_ready = 1'b0; frame_done_in = 1'b0;
        check("xfer_valid_drop", int'(cfg_valid), 0);

        // Settle: two discarded frames, then the third frame is evaluated
        for (int f = 0; f < 2; f++) begin
            pulse_frame(8'd0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("settle_no_valid", int'(cfg_valid), 0);
            end
        end
        eval_frame(8'd40, v);
        check("settle3_valid", int'(v), 1);
        check("settle3_exp", int'(exp_out), 648);
        finish_issue();

        // Table of single-frame steps: climb to saturation, gain, bright, deadband
        for (int i = 0; i < 15; i++) begin
            target_luma = tv[i].tgt;
            eval_frame(tv[i].avg, v);
            check($sformatf("tv%0d_valid", i), int'(v), int'(tv[i].vld));
            check($sformatf("tv%0d_exp", i), int'(exp_out), tv[i].expv);
            check($sformatf("tv%0d_gain", i), int'(gain_out), tv[i].gain);
            check($sformatf("tv%0d_lock", i), int'(ae_locked), int'(tv[i].lock));
            if (v) finish_issue();
        end

        // Loop disabled: setting and lock hold
        target_luma = 8'd110;
        ae_enable = 1'b0;
        eval_frame(8'd40, v);
        check("dis_valid", int'(v), 0);
        check("dis_lock", int'(ae_locked), 1);
        check("dis_exp", int'(exp_out), 1163);
        ae_enable = 1'b1;
        @(negedge clk);

        // Dropping ae_enable in SETTLE returns to IDLE without waiting for frames
        eval_frame(8'd40, v);
        check("clamp_valid", int'(v), 1);
        check("clamp_exp", int'(exp_out), 1200);
        cfg_ready = 1'b1;
        @(negedge clk);
        cfg_ready = 1'b0; ae_enable = 1'b0;
        @(negedge clk);
        ae_enable = 1'b1;
        eval_frame(8'd20, v);
        check("settle_abort_valid", int'(v), 1);
        check("settle_abort_gain", int'(gain_out), 17);
        finish_issue();

        // Bright descent to the floor, bounded at 50 frames
        for (int k = 0; k < 50; k++) begin
            eval_frame(8'd250, v);
            if (v) finish_issue();
        end
        check("floor_exp", int'(exp_out), 16);
        check("floor_gain", int'(gain_out), 16);
        eval_frame(8'd250, v);
        check("floor_valid", int'(v), 0);
        check("floor_lock", int'(ae_locked), 0);
        eval_frame(8'd115, v);
        check("db_valid", int'(v), 0);
        check("db_lock", int'(ae_locked), 1);

        // Reset while a setting is waiting for the register writer
        eval_frame(8'd40, v);
        check("pre_rst_valid", int'(v), 1);
        check("pre_rst_exp", int'(exp_out), 18);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_valid", int'(cfg_valid), 0);
        check("midrst_exp", int'(exp_out), 512);
        check("midrst_lock", int'(ae_locked), 0);
        eval_frame(8'd40, v);
        check("post_rst_valid", int'(v), 1);
        check("post_rst_exp", int'(exp_out), 576);
        finish_issue();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
